bootloader_fetch_responder: RTL and testbench

Responder end of the instruction-fetch bootloader request path. It accepts `bootloader_req_t` fetch requests (valid, id, paddr) issued while the hart executes M-mode code in the bootloader region. For each request it reads four consecutive 32-bit words from a synchronous bootloader ROM and returns them as one fetch packet to the instruction fetch queue. It sits between the icache request arbiter and the bootloader ROM macro, in parallel with the icache response path.

---
 rtl/bootloader_fetch_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_bootloader_fetch_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bootloader_fetch_responder.sv
// Bootloader fetch responder: buffers fetch requests, reads four consecutive ROM
// words per request and returns them as one packet to the instruction fetch queue.
package bootloader_fetch_pkg;
    localparam int PADDR_WIDTH = 32;

    typedef struct packed {
        logic                   valid;
        logic [31:0]            id;
        logic [PADDR_WIDTH-1:0] paddr;
    } bootloader_req_t;
endpackage

module bootloader_fetch_responder
    import bootloader_fetch_pkg::*;
#(
    parameter logic [PADDR_WIDTH-1:0] ROM_BASE   = 32'h0000_1000,
    parameter int                     ROM_WORDS  = 1024,
    parameter int                     FIFO_DEPTH = 2,
    localparam int                    AW         = $clog2(ROM_WORDS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  bootloader_req_t        req_in,
    input  logic                   flush,
    output logic                   stall_out,
    output logic                   rom_en,
    output logic [AW-1:0]          rom_addr,
    input  logic [31:0]            rom_rdata,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_id,
    output logic [PADDR_WIDTH-1:0] res_paddr,
    output logic [3:0][31:0]       res_instr,
    output logic [3:0]             res_word_valid
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]          DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0]          LAST_PTR    = PW'(FIFO_DEPTH - 1);
    localparam logic [PADDR_WIDTH:0]   ROM_WORDS_W = (PADDR_WIDTH + 1)'(ROM_WORDS);
    localparam logic [PADDR_WIDTH-1:0] WORD_MASK   = {{(PADDR_WIDTH - 2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_RESP} state_t;

    // Word index relative to ROM word 0; one extra bit keeps below-base addresses distinct.
    function automatic logic [PADDR_WIDTH:0] word_addr(input logic [PADDR_WIDTH-1:0] paddr,
                                                       input logic [1:0] k);
        logic [PADDR_WIDTH:0] off;
        off = {1'b0, paddr} - {1'b0, ROM_BASE};
        return (off >> 2) + {{(PADDR_WIDTH - 1){1'b0}}, k};
    endfunction

    function automatic logic in_rom(input logic [PADDR_WIDTH-1:0] paddr, input logic [1:0] k);
        return (paddr >= ROM_BASE) && (word_addr(paddr, k) < ROM_WORDS_W);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? {PW{1'b0}} : p + {{(PW - 1){1'b0}}, 1'b1};
    endfunction

    state_t                 state_r, state_nxt_s;
    logic [1:0]             k_r, k_nxt_s;
    logic [31:0]            id_mem_r    [FIFO_DEPTH];
    logic [PADDR_WIDTH-1:0] paddr_mem_r [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]          cnt_r, cnt_nxt_s;
    logic                   stall_r, fifo_empty_s, push_s, pop_s;
    logic [31:0]            cur_id_r;
    logic [PADDR_WIDTH-1:0] cur_paddr_r, nxt_paddr_s;
    logic [PADDR_WIDTH:0]   nxt_w_s;
    logic                   rom_en_r, rom_en_nxt_s;
    logic [AW-1:0]          rom_addr_r, rom_addr_nxt_s;
    logic                   issue_s, issue_in_s;
    logic                   pend_valid_r, pend_in_r;
    logic [1:0]             pend_slot_r;
    logic [3:0][31:0]       instr_r;
    logic [3:0]             wvalid_r;
    logic                   res_valid_r, res_valid_nxt_s;

    assign fifo_empty_s = (cnt_r == {CW{1'b0}});
    assign push_s       = req_in.valid && !stall_r && !flush;

    // FIFO occupancy update; full is flagged from the post-edge count only.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (flush) begin
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   cnt_nxt_s = cnt_r + {{(CW - 1){1'b0}}, 1'b1};
                2'b01:   cnt_nxt_s = cnt_r - {{(CW - 1){1'b0}}, 1'b1};
                default: cnt_nxt_s = cnt_r;
            endcase
        end
    end

    // Request FIFO storage, pointers and full flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            stall_r  <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                id_mem_r[i]    <= 32'h0;
                paddr_mem_r[i] <= {PADDR_WIDTH{1'b0}};
            end
        end else begin
            cnt_r   <= cnt_nxt_s;
            stall_r <= (cnt_nxt_s == DEPTH_C);
            if (flush) begin
                wr_ptr_r <= {PW{1'b0}};
                rd_ptr_r <= {PW{1'b0}};
            end else begin
                if (push_s) begin
                    id_mem_r[wr_ptr_r]    <= req_in.id;
                    paddr_mem_r[wr_ptr_r] <= req_in.paddr;
                    wr_ptr_r              <= ptr_inc(wr_ptr_r);
                end
                if (pop_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            k_r     <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            k_r     <= k_nxt_s;
        end
    end

    // FSM next-state logic; flush wins over every transition.
    always_comb begin
        state_nxt_s = state_r;
        k_nxt_s     = k_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
            k_nxt_s     = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_nxt_s = ST_READ;
                        k_nxt_s     = 2'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (k_r == 2'd3) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        k_nxt_s = k_r + 2'd1;
                    end
                end
                ST_DRAIN: state_nxt_s = ST_RESP;
                ST_RESP: begin
                    if (res_ready && !fifo_empty_s) begin
                        state_nxt_s = ST_READ;
                        k_nxt_s     = 2'd0;
                    end else if (res_ready) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    k_nxt_s     = 2'd0;
                end
            endcase
        end
    end

    // FSM outputs: ROM controls are computed for the next cycle so they can be registered.
    always_comb begin
        pop_s = !flush && !fifo_empty_s &&
                ((state_r == ST_IDLE) || ((state_r == ST_RESP) && res_ready));
        if (pop_s) begin
            nxt_paddr_s = paddr_mem_r[rd_ptr_r] & WORD_MASK;
        end else begin
            nxt_paddr_s = cur_paddr_r;
        end
        nxt_w_s      = word_addr(nxt_paddr_s, k_nxt_s);
        rom_en_nxt_s = (state_nxt_s == ST_READ) && in_rom(nxt_paddr_s, k_nxt_s);
        if (rom_en_nxt_s) begin
            rom_addr_nxt_s = nxt_w_s[AW-1:0];
        end else begin
            rom_addr_nxt_s = {AW{1'b0}};
        end
        issue_s         = (state_r == ST_READ);
        issue_in_s      = in_rom(cur_paddr_r, k_r);
        res_valid_nxt_s = (state_nxt_s == ST_RESP);
    end

    // Packet datapath: current request, ROM capture pipeline and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_id_r     <= 32'h0;
            cur_paddr_r  <= {PADDR_WIDTH{1'b0}};
            rom_en_r     <= 1'b0;
            rom_addr_r   <= {AW{1'b0}};
            pend_valid_r <= 1'b0;
            pend_in_r    <= 1'b0;
            pend_slot_r  <= 2'd0;
            instr_r      <= {4{32'h0}};
            wvalid_r     <= 4'b0000;
            res_valid_r  <= 1'b0;
        end else begin
            rom_en_r     <= rom_en_nxt_s;
            rom_addr_r   <= rom_addr_nxt_s;
            res_valid_r  <= res_valid_nxt_s;
            pend_valid_r <= issue_s && !flush;
            pend_in_r    <= issue_in_s;
            pend_slot_r  <= k_r;
            if (pop_s) begin
                cur_id_r    <= id_mem_r[rd_ptr_r];
                cur_paddr_r <= nxt_paddr_s;
            end
            if (issue_s && !flush) begin
                wvalid_r[k_r] <= issue_in_s;
            end
            // Data returns one cycle after the issue; out-of-range slots read as zero.
            if (pend_valid_r && !flush) begin
                instr_r[pend_slot_r] <= pend_in_r ? rom_rdata : 32'h0;
            end
        end
    end

    assign stall_out      = stall_r;
    assign rom_en         = rom_en_r;
    assign rom_addr       = rom_addr_r;
    assign res_valid      = res_valid_r;
    assign res_id         = cur_id_r;
    assign res_paddr      = cur_paddr_r;
    assign res_instr      = instr_r;
    assign res_word_valid = wvalid_r;

endmodule

// File: tb/tb_bootloader_fetch_responder.sv
// Directed bench for bootloader_fetch_responder with a behavioural synchronous ROM.
module tb_bootloader_fetch_responder;
    import bootloader_fetch_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n;
    bootloader_req_t        req_in;
    logic                   flush;
    logic                   stall_out;
    logic                   rom_en;
    logic [9:0]             rom_addr;
    logic [31:0]            rom_rdata;
    logic                   res_valid;
    logic                   res_ready;
    logic [31:0]            res_id;
    logic [PADDR_WIDTH-1:0] res_paddr;
    logic [3:0][31:0]       res_instr;
    logic [3:0]             res_word_valid;

    int total = 0;
    int bad   = 0;

    bootloader_fetch_responder dut (
        .clock(clock), .reset_n(reset_n), .req_in(req_in), .flush(flush),
        .stall_out(stall_out), .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_paddr(res_paddr),
        .res_instr(res_instr), .res_word_valid(res_word_valid)
    );

    always #5 clock = ~clock;

    // ROM word i holds A000_0000 + i, one-cycle read latency.
    always @(posedge clock) begin
        if (rom_en) rom_rdata <= 32'hA000_0000 + {22'h0, rom_addr};
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents a request for one edge (E0); returns in cycle 0.
    task automatic send(input logic [31:0] id, input logic [31:0] paddr);
        req_in.valid = 1'b1;
        req_in.id    = id;
        req_in.paddr = paddr;
        step();
        req_in.valid = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    int seen;

    initial begin
        reset_n   = 1'b0;
        req_in    = '0;
        flush     = 1'b0;
        res_ready = 1'b0;
        rom_rdata = 32'h0;
        repeat (3) step();
        check_val("reset_ctrl", {stall_out, rom_en, res_valid}, 3'b000);
        check_val("reset_res", {res_id, res_paddr, res_word_valid}, 68'h0);
        check_val("reset_instr", res_instr, 128'h0);
        reset_n = 1'b1;
        step();

        // Basic fetch, paddr 0x1008 -> words 2..5.
        send(32'd7, 32'h0000_1008);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_val($sformatf("t1_rom_c%0d", c), {rom_en, rom_addr}, {1'b1, 10'(c + 1)});
        end
        step();
        check_val("t1_drain", {rom_en, res_valid}, 2'b00);
        step();
        check_val("t1_valid", res_valid, 1'b1);
        check_val("t1_instr", res_instr, {32'hA000_0005, 32'hA000_0004, 32'hA000_0003, 32'hA000_0002});
        check_val("t1_meta", {res_word_valid, res_id, res_paddr}, {4'b1111, 32'd7, 32'h0000_1008});
        handshake();
        check_val("t1_drop", res_valid, 1'b0);

        // Top-of-ROM fetch: only words 1022/1023 exist.
        send(32'd5, 32'h0000_1FF8);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_val($sformatf("t2_rom_c%0d", c), rom_en, (c <= 2) ? 1'b1 : 1'b0);
        end
        repeat (2) step();
        check_val("t2_valid", res_valid, 1'b1);
        check_val("t2_wv", res_word_valid, 4'b0011);
        check_val("t2_instr", res_instr, {32'h0, 32'h0, 32'hA000_03FF, 32'hA000_03FE});
        handshake();

        // Below-base fetch: nothing in range.
        send(32'd6, 32'h0000_0FF8);
        seen = 0;
        repeat (6) begin
            step();
            if (rom_en) seen++;
        end
        check_val("t2b_rom_en", seen, 0);
        check_val("t2b_wv", {res_valid, res_word_valid}, 5'b1_0000);
        handshake();

        // Three requests with the IFQ stalled, then a refused fourth.
        req_in = '{1'b1, 32'd1, 32'h0000_1000};
        step();
        check_val("t3_stall_c0", stall_out, 1'b0);
        req_in = '{1'b1, 32'd2, 32'h0000_1010};
        step();
        check_val("t3_stall_c1", stall_out, 1'b0);
        req_in = '{1'b1, 32'd3, 32'h0000_1020};
        step();
        check_val("t3_stall_c2", stall_out, 1'b1);
        req_in = '{1'b1, 32'd4, 32'h0000_1030};
        repeat (2) step();
        req_in.valid = 1'b0;
        repeat (2) step();
        check_val("t3_r1", {res_valid, res_id, res_instr[0], stall_out}, {1'b1, 32'd1, 32'hA000_0000, 1'b1});
        res_ready = 1'b1;
        step();
        check_val("t3_after1", {res_valid, stall_out}, 2'b00);
        repeat (5) step();
        check_val("t3_r2", {res_valid, res_id, res_instr[0]}, {1'b1, 32'd2, 32'hA000_0004});
        step();
        check_val("t3_gap2", res_valid, 1'b0);
        repeat (5) step();
        check_val("t3_r3", {res_valid, res_id, res_instr[0]}, {1'b1, 32'd3, 32'hA000_0008});
        seen = 0;
        repeat (10) begin
            step();
            if (res_valid) seen++;
        end
        check_val("t3_no_r4", seen, 0);
        res_ready = 1'b0;

        // Flush in cycle 3 of READ, with a request in the flush cycle.
        send(32'd8, 32'h0000_1000);
        repeat (3) step();
        flush  = 1'b1;
        req_in = '{1'b1, 32'd11, 32'h0000_1000};
        step();
        flush        = 1'b0;
        req_in.valid = 1'b0;
        check_val("t4_flush", {rom_en, stall_out}, 2'b00);
        seen = 0;
        repeat (10) begin
            step();
            if (res_valid || rom_en) seen++;
        end
        check_val("t4_quiet", seen, 0);
        send(32'd9, 32'h0000_1040);
        repeat (5) step();
        check_val("t4_c5", res_valid, 1'b0);
        step();
        check_val("t4_r9", {res_valid, res_id, res_instr[3]}, {1'b1, 32'd9, 32'hA000_0013});
        handshake();

        // Response held for 10 cycles.
        send(32'd12, 32'h0000_1100);
        repeat (6) step();
        seen = 0;
        repeat (10) begin
            if ({res_valid, rom_en, res_id, res_paddr, res_word_valid} !==
                {1'b1, 1'b0, 32'd12, 32'h0000_1100, 4'b1111}) seen++;
            if (res_instr !== {32'hA000_0043, 32'hA000_0042, 32'hA000_0041, 32'hA000_0040}) seen++;
            step();
        end
        check_val("t5_hold", seen, 0);
        handshake();
        step();
        check_val("t5_idle", {res_valid, rom_en}, 2'b00);

        // Asynchronous reset during DRAIN.
        send(32'd13, 32'h0000_1000);
        repeat (5) step();
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_ctrl", {stall_out, rom_en, res_valid, res_word_valid}, 7'h0);
        check_val("t6_rst_res", {res_id, res_paddr, res_instr}, 192'h0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        send(32'd14, 32'h0000_1006);
        repeat (5) step();
        check_val("t6_c5", res_valid, 1'b0);
        step();
        check_val("t6_r14", {res_valid, res_id, res_paddr}, {1'b1, 32'd14, 32'h0000_1004});
        check_val("t6_instr", res_instr, {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001});
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
